// File: rtl/mem_stage_module.sv
// MEM pipeline stage: issues one memory request per load/store, stalls the
// pipeline until the memory acknowledges, then hands the result to MEM/WB.
// The access FSM state is exported on state_dbg (IDLE=0, ACCESS=1, DONE=2).
//
// Handshake: mem_req is a registered request that stays high, with mem_we,
// mem_addr and mem_wdata held stable, until the first cycle where mem_ack=1
// is seen in ACCESS; mem_rdata is sampled only in that cycle. ready is the
// pipeline-wide advance signal: when it is 0 every upstream stage is frozen
// and the MEM/WB register holds.
module mem_stage_module #(
   parameter logic [31:0] ADDR_OFFSET = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] val_r_m_in,
   input  logic [3:0]  dest_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        ready,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] mem_data_out,
   output logic [3:0]  dest_out,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        access_req;
   logic        is_read;
   logic [31:0] addr_calc;
   logic [31:0] load_reg;

   // A simultaneous read+write request is carried out as a write, so only a
   // pure read delivers load data to MEM/WB.
   assign access_req = mem_r_en_in | mem_w_en_in;
   assign is_read    = mem_r_en_in & ~mem_w_en_in;
   // Wraps modulo 2^32 when alu_res_in is below the offset.
   assign addr_calc  = alu_res_in - ADDR_OFFSET;
   assign state_dbg  = state;

   // Access FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and ready decode: the pipeline only advances from IDLE with
   // no access pending, or in the single DONE cycle after an access.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            if (access_req) begin
               state_next = ACCESS;
            end else begin
               ready = 1'b1;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_next = DONE;
            end
         end
         DONE: begin
            ready      = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Memory-side registers: launch the request from IDLE, drop it and
   // capture read data on the acknowledge in ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         load_reg  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (access_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= mem_w_en_in;
                  mem_addr  <= {addr_calc[31:2], 2'b00};
                  mem_wdata <= val_r_m_in;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  load_reg <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // MEM/WB pipeline register: advances with the rest of the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_out    <= 1'b0;
         mem_r_en_out <= 1'b0;
         alu_res_out  <= 32'd0;
         mem_data_out <= 32'd0;
         dest_out     <= 4'd0;
      end else if (ready) begin
         wb_en_out    <= wb_en_in;
         mem_r_en_out <= mem_r_en_in;
         alu_res_out  <= alu_res_in;
         dest_out     <= dest_in;
         if (is_read) begin
            mem_data_out <= load_reg;
         end
      end
   end

endmodule
